// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Brief    : Multi-cycle MIPS32 main control unit. Steps the shared datapath
//            through one instruction at a time, counts retired instructions
//            and traps on illegal opcodes or memory handshake timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        i_or_d,
    output logic        ir_wr,
    output logic        pc_wr,
    output logic        reg_wr,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        instr_done,
    output logic [31:0] instr_count,
    output logic        illegal,
    output logic        bus_err,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BEQEX  = 4'd10,
        S_JEX    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int              CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [31:0]   instr_count_q, instr_count_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          illegal_q, illegal_d;
    logic          bus_err_q, bus_err_d;

    logic          w_mem_state;
    logic          w_timeout;
    logic          w_unused_funct;

    // funct is consumed by the ALU decoder, not by this unit.
    assign w_unused_funct = ^funct;

    assign w_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                         (state_q == S_MEMWR);
    // A same-cycle mem_ready always beats the timeout.
    assign w_timeout   = (wait_cnt_q == WAIT_LAST) && !mem_ready;

    // Datapath enables and selects decoded from the current state.
    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        i_or_d     = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                ir_wr     = mem_ready;
                pc_wr     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_rd = 1'b1;
                i_or_d = 1'b1;
            end
            S_MEMWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_wr     = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_RTEX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_wr     = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                reg_wr     = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_wr      = zero;
                instr_done = 1'b1;
            end
            S_JEX: begin
                pc_src     = 2'b10;
                pc_wr      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state, retire counter, wait counter and sticky trap causes.
    always_comb begin
        state_d       = state_q;
        instr_count_d = instr_count_q;
        illegal_d     = illegal_q;
        bus_err_d     = bus_err_q;
        wait_cnt_d    = '0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (w_timeout) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = S_RTEX;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BEQEX;
                    OP_ADDI:       state_d = S_ADDIEX;
                    OP_J:          state_d = S_JEX;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (w_timeout) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (w_timeout) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_RTEX:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQEX, S_JEX: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default: begin
                state_d = S_TRAP;
            end
        endcase

        if (instr_done) begin
            instr_count_d = instr_count_q + 32'd1;
        end

        // Count only consecutive stalled cycles within the same memory state;
        // entry, completion or leaving the state clears it.
        if (w_mem_state && !mem_ready && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FETCH;
            instr_count_q <= 32'd0;
            wait_cnt_q    <= '0;
            illegal_q     <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
            wait_cnt_q    <= wait_cnt_d;
            illegal_q     <= illegal_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign instr_count = instr_count_q;
    assign illegal     = illegal_q;
    assign bus_err     = bus_err_q;
    assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control
// Brief    : Directed self-checking bench for mc_control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_rd, mem_wr, i_or_d, ir_wr, pc_wr, reg_wr, reg_dst;
    logic        mem_to_reg, alu_src_a, instr_done, illegal, bus_err;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic [31:0] instr_count;
    logic [3:0]  state;
    logic [15:0] ctl;

    int checks = 0;
    int errors = 0;

    mc_control #(.TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .i_or_d      (i_or_d),
        .ir_wr       (ir_wr),
        .pc_wr       (pc_wr),
        .reg_wr      (reg_wr),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .pc_src      (pc_src),
        .instr_done  (instr_done),
        .instr_count (instr_count),
        .illegal     (illegal),
        .bus_err     (bus_err),
        .state       (state)
    );

    // Control bundle: mem_rd mem_wr i_or_d ir_wr | pc_wr reg_wr reg_dst mem_to_reg |
    //                 alu_src_a alu_src_b[1:0] alu_op[1] | alu_op[0] pc_src[1:0] instr_done
    assign ctl = {mem_rd, mem_wr, i_or_d, ir_wr, pc_wr, reg_wr, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, alu_op, pc_src, instr_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        opcode    = 6'h00;
        mem_ready = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (state !== 4'd6) begin
            errors++;
            $display("FAIL reset_pre state=%0d exp=6", state);
        end
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || ctl !== 16'h8020 || instr_count !== 32'd0 ||
            illegal !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_async state=%0d ctl=%h cnt=%0d ill=%b berr=%b exp 0/8020/0/0/0",
                     state, ctl, instr_count, illegal, bus_err);
        end
        tick();
        checks++;
        if (state !== 4'd0 || ctl !== 16'h8020) begin
            errors++;
            $display("FAIL reset_hold state=%0d ctl=%h exp 0/8020", state, ctl);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_rtype();
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        logic [15:0] ec [4] = '{16'h9820, 16'h0060, 16'h0090, 16'h0601};
        do_reset();
        opcode = 6'h00;
        funct  = 6'h20;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (state !== es[i] || ctl !== ec[i]) begin
                errors++;
                $display("FAIL rtype_c%0d state=%0d ctl=%h exp %0d/%h", i + 1, state, ctl, es[i], ec[i]);
            end
            tick();
        end
        checks++;
        if (instr_count !== 32'd1 || state !== 4'd0) begin
            errors++;
            $display("FAIL rtype_retire cnt=%0d state=%0d exp 1/0", instr_count, state);
        end
    endtask

    task automatic test_lw();
        logic        rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0]  es [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        logic [15:0] ec [8] = '{16'h9820, 16'h0060, 16'h00C0, 16'hA000,
                                16'hA000, 16'hA000, 16'hA000, 16'h0501};
        do_reset();
        opcode = 6'h23;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rd[i];
            #1;
            checks++;
            if (state !== es[i] || ctl !== ec[i]) begin
                errors++;
                $display("FAIL lw_c%0d state=%0d ctl=%h exp %0d/%h", i + 1, state, ctl, es[i], ec[i]);
            end
            tick();
        end
        checks++;
        if (instr_count !== 32'd1 || state !== 4'd0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL lw_retire cnt=%0d state=%0d berr=%b exp 1/0/0", instr_count, state, bus_err);
        end
    endtask

    task automatic test_sw();
        logic        rd [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
        logic [15:0] ec [5] = '{16'h9820, 16'h0060, 16'h00C0, 16'h6000, 16'h6001};
        do_reset();
        opcode = 6'h2B;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rd[i];
            #1;
            checks++;
            if (state !== es[i] || ctl !== ec[i]) begin
                errors++;
                $display("FAIL sw_c%0d state=%0d ctl=%h exp %0d/%h", i + 1, state, ctl, es[i], ec[i]);
            end
            tick();
        end
        checks++;
        if (instr_count !== 32'd1 || state !== 4'd0) begin
            errors++;
            $display("FAIL sw_retire cnt=%0d state=%0d exp 1/0", instr_count, state);
        end
    endtask

    task automatic test_addi();
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd8, 4'd9};
        logic [15:0] ec [4] = '{16'h9820, 16'h0060, 16'h00C0, 16'h0401};
        do_reset();
        opcode = 6'h08;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (state !== es[i] || ctl !== ec[i]) begin
                errors++;
                $display("FAIL addi_c%0d state=%0d ctl=%h exp %0d/%h", i + 1, state, ctl, es[i], ec[i]);
            end
            tick();
        end
        checks++;
        if (instr_count !== 32'd1) begin
            errors++;
            $display("FAIL addi_retire cnt=%0d exp 1", instr_count);
        end
    endtask

    task automatic test_beq(input logic z);
        logic [3:0]  es [3] = '{4'd0, 4'd1, 4'd10};
        logic [15:0] ec [3] = '{16'h9820, 16'h0060, 16'h008B};
        do_reset();
        opcode = 6'h04;
        zero   = z;
        if (z) ec[2] = 16'h088B;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            #1;
            checks++;
            if (state !== es[i] || ctl !== ec[i]) begin
                errors++;
                $display("FAIL beq_z%0b_c%0d state=%0d ctl=%h exp %0d/%h", z, i + 1, state, ctl, es[i], ec[i]);
            end
            tick();
        end
        checks++;
        if (instr_count !== 32'd1 || state !== 4'd0) begin
            errors++;
            $display("FAIL beq_z%0b_retire cnt=%0d state=%0d exp 1/0", z, instr_count, state);
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal();
        do_reset();
        opcode    = 6'h3F;
        mem_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (state !== 4'd12 || illegal !== 1'b1 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_trap state=%0d ill=%b berr=%b exp 12/1/0", state, illegal, bus_err);
        end
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            zero      = i[1];
            #1;
            checks++;
            if (ctl !== 16'h0000 || state !== 4'd12 || illegal !== 1'b1) begin
                errors++;
                $display("FAIL illegal_hold_c%0d ctl=%h state=%0d ill=%b exp 0000/12/1", i, ctl, state, illegal);
            end
            tick();
        end
        do_reset();
        checks++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear state=%0d ill=%b exp 0/0", state, illegal);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        opcode    = 6'h00;
        mem_ready = 1'b0;
        repeat (14) tick();
        checks++;
        if (state !== 4'd0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_c14 state=%0d berr=%b exp 0/0", state, bus_err);
        end
        tick();
        checks++;
        if (state !== 4'd12 || bus_err !== 1'b1 || illegal !== 1'b0 || ctl !== 16'h0000) begin
            errors++;
            $display("FAIL timeout_trap state=%0d berr=%b ill=%b ctl=%h exp 12/1/0/0000",
                     state, bus_err, illegal, ctl);
        end
        do_reset();
        mem_ready = 1'b0;
        repeat (14) tick();
        mem_ready = 1'b1;
        tick();
        checks++;
        if (state !== 4'd1 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rescue state=%0d berr=%b exp 1/0", state, bus_err);
        end
    endtask

    task automatic test_jump_wrap();
        logic [3:0]  es [3] = '{4'd0, 4'd1, 4'd11};
        logic [15:0] ec [3] = '{16'h9820, 16'h0060, 16'h0805};
        do_reset();
        opcode = 6'h02;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            if (i == 2) force dut.instr_count_q = 32'hFFFF_FFFF;
            #1;
            checks++;
            if (state !== es[i] || ctl !== ec[i]) begin
                errors++;
                $display("FAIL jump_c%0d state=%0d ctl=%h exp %0d/%h", i + 1, state, ctl, es[i], ec[i]);
            end
            if (i == 2) release dut.instr_count_q;
            tick();
        end
        checks++;
        if (instr_count !== 32'd0 || state !== 4'd0) begin
            errors++;
            $display("FAIL jump_wrap cnt=%h state=%0d exp 00000000/0", instr_count, state);
        end
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 6'h00;
        funct     = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw();
        test_sw();
        test_addi();
        test_beq(1'b1);
        test_beq(1'b0);
        test_illegal();
        test_timeout();
        test_jump_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
